fifo_byte_packer: RTL and testbench

- Upstream write-side stage for the FIFO memory.
- Accepts an 8-bit valid/ready byte stream and packs bytes little-endian into WIDTH-bit words.
- Drives the memory's mem_wr_en and fifo_wr_data.
- Keeps a shadow occupancy count, driven by mem_wr_en and the consumer's mem_rd_en, so it never writes into a full memory.

---
 rtl/fifo_byte_packer_pkg.sv | 22 ++
 rtl/fifo_byte_packer_if.sv | 29 ++
 rtl/fifo_occupancy_cnt.sv | 75 +++++++
 rtl/fifo_byte_packer.sv | 122 ++++++++++++
 tb/tb_fifo_byte_packer.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_byte_packer_pkg.sv
// Shared constants and types for the FIFO write-side byte packer.
// Contents: default widths (BYTE_W, BPW, CNT_W), the packer state type,
// and a helper that sizes the lane index.
package fifo_byte_packer_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned WIDTH_DEF      = 32;
    localparam int unsigned FIFO_DEPTH_DEF = 32;
    localparam int unsigned BPW            = WIDTH_DEF / BYTE_W;
    localparam int unsigned CNT_W          = $clog2(FIFO_DEPTH_DEF + 1);

    typedef enum logic {
        FILL = 1'b0,
        PUSH = 1'b1
    } pack_state_t;

    // Width of a lane index; a single-lane word still needs one bit.
    function automatic int unsigned lane_w(input int unsigned bpw);
        return (bpw > 1) ? $clog2(bpw) : 1;
    endfunction

endpackage

// File: rtl/fifo_byte_packer_if.sv
// Byte-stream input and memory write-side signals of the byte packer.
// Modports:
//   master - byte source / memory side (drives in_*, mem_rd_en, wr_full_err)
//   slave  - the packer (drives in_ready, mem_wr_en, fifo_wr_data)
interface fifo_byte_packer_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned BYTE_W = 8
) ();

    logic              in_valid;
    logic [BYTE_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              mem_wr_en;
    logic [WIDTH-1:0]  fifo_wr_data;
    logic              mem_rd_en;
    logic              wr_full_err;

    modport master (
        output in_valid, in_data, in_last, mem_rd_en, wr_full_err,
        input  in_ready, mem_wr_en, fifo_wr_data
    );

    modport slave (
        input  in_valid, in_data, in_last, mem_rd_en, wr_full_err,
        output in_ready, mem_wr_en, fifo_wr_data
    );

endinterface

// File: rtl/fifo_occupancy_cnt.sv
// Shadow word count of the downstream FIFO memory.
// Ports:
//   CLK, RST    - clock, synchronous active-high reset
//   inc         - a word is written this cycle (mem_wr_en)
//   dec         - a word is read this cycle (mem_rd_en)
//   occupancy   - registered word count, 0..FIFO_DEPTH
//   full        - registered, occupancy == FIFO_DEPTH
//   almost_full - registered, only with FIFO_ALMOST_FULL_EN defined
// Optional feature macro: FIFO_ALMOST_FULL_EN (adds AF_MARGIN / almost_full).
module fifo_occupancy_cnt #(
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
`ifdef FIFO_ALMOST_FULL_EN
    ,
    parameter int unsigned AF_MARGIN  = 4
`endif
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] occupancy,
    output logic             full
`ifdef FIFO_ALMOST_FULL_EN
    ,
    output logic             almost_full
`endif
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [CNT_W-1:0] occ_q, occ_d;
    logic             full_q;

    // Saturating update: simultaneous inc/dec cancel, empty reads hold at 0.
    always_comb begin
        occ_d = occ_q;
        if (inc && !dec && (occ_q != DEPTH_C)) begin
            occ_d = occ_q + CNT_W'(1);
        end else if (dec && !inc && (occ_q != '0)) begin
            occ_d = occ_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            occ_q  <= '0;
            full_q <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            full_q <= (occ_d == DEPTH_C);
        end
    end

    assign occupancy = occ_q;
    assign full      = full_q;

`ifdef FIFO_ALMOST_FULL_EN
    localparam logic [CNT_W-1:0] AF_TH_C = CNT_W'(FIFO_DEPTH - AF_MARGIN);

    logic af_q;

    // Flag tracks the count being loaded this edge, so it lines up with occupancy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            af_q <= 1'b0;
        end else begin
            af_q <= (occ_d >= AF_TH_C);
        end
    end

    assign almost_full = af_q;
`endif

endmodule

// File: rtl/fifo_byte_packer.sv
// Write-side stage for the FIFO memory: packs an 8-bit valid/ready byte
// stream little-endian into WIDTH-bit words and writes them to the memory,
// never writing while the shadow occupancy count says the memory is full.
// Ports:
//   CLK, RST   - clock, synchronous active-high reset (memory nRST = ~RST)
//   bus        - fifo_byte_packer_if.slave: in_valid/in_data/in_last/in_ready
//                byte stream, mem_wr_en/fifo_wr_data write port, mem_rd_en
//                consumer read strobe, wr_full_err memory overflow flag
//   occupancy  - shadow word count
//   full       - occupancy == FIFO_DEPTH
//   pack_err   - sticky, set by any wr_full_err pulse
//   almost_full- only with FIFO_ALMOST_FULL_EN defined
// Optional feature macro: FIFO_ALMOST_FULL_EN (adds AF_MARGIN / almost_full).
module fifo_byte_packer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned BYTE_W     = fifo_byte_packer_pkg::BYTE_W,
    parameter int unsigned FIFO_DEPTH = 32
`ifdef FIFO_ALMOST_FULL_EN
    ,
    parameter int unsigned AF_MARGIN  = 4
`endif
) (
    input  logic                               CLK,
    input  logic                               RST,
    fifo_byte_packer_if.slave                  bus,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    occupancy,
    output logic                               full,
    output logic                               pack_err
`ifdef FIFO_ALMOST_FULL_EN
    ,
    output logic                               almost_full
`endif
);

    import fifo_byte_packer_pkg::*;

    localparam int unsigned BPW_L  = WIDTH / BYTE_W;
    localparam int unsigned LANE_W = lane_w(BPW_L);
    localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);

    pack_state_t       state_q, state_d;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [WIDTH-1:0]  word_q, word_d;
    logic              in_ready_q;
    logic              pack_err_q;
    logic              wr_fire_c;

    // A held word goes out as soon as the shadow count has room.
    assign wr_fire_c = (state_q == PUSH) && !full;

    // Next-state: fill lanes in FILL, release the word in PUSH.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        case (state_q)
            FILL: begin
                if (bus.in_valid) begin
                    word_d[lane_q*BYTE_W +: BYTE_W] = bus.in_data;
                    lane_d = lane_q + LANE_W'(1);
                    // in_last flush leaves the upper lanes at their cleared 0.
                    if ((lane_q == LANE_W'(BPW_L - 1)) || bus.in_last) begin
                        state_d = PUSH;
                    end
                end
            end
            PUSH: begin
                if (wr_fire_c) begin
                    state_d = FILL;
                    lane_d  = '0;
                    word_d  = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= FILL;
            lane_q     <= '0;
            word_q     <= '0;
            in_ready_q <= 1'b1;
            pack_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            word_q     <= word_d;
            in_ready_q <= (state_d == FILL);
            pack_err_q <= pack_err_q | bus.wr_full_err;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.mem_wr_en    = wr_fire_c;
    assign bus.fifo_wr_data = word_q;
    assign pack_err         = pack_err_q;

    // Shadow count of the memory, fed by the same strobes the memory sees.
    fifo_occupancy_cnt #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (OCC_W)
`ifdef FIFO_ALMOST_FULL_EN
        ,
        .AF_MARGIN  (AF_MARGIN)
`endif
    ) u_occ (
        .CLK         (CLK),
        .RST         (RST),
        .inc         (wr_fire_c),
        .dec         (bus.mem_rd_en),
        .occupancy   (occupancy),
        .full        (full)
`ifdef FIFO_ALMOST_FULL_EN
        ,
        .almost_full (almost_full)
`endif
    );

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Self-checking bench for fifo_byte_packer: a queue-based word model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fifo_byte_packer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned BW    = 8;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned NBPW  = WIDTH / BW;
    localparam int unsigned AFM   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] occ;
    logic       full;
    logic       perr;
`ifdef FIFO_ALMOST_FULL_EN
    logic       af;
`endif

    int tests = 0;
    int fails = 0;

    fifo_byte_packer_if #(.WIDTH(WIDTH), .BYTE_W(BW)) bus ();

    fifo_byte_packer #(
        .WIDTH      (WIDTH),
        .BYTE_W     (BW),
        .FIFO_DEPTH (DEPTH)
`ifdef FIFO_ALMOST_FULL_EN
        ,
        .AF_MARGIN  (AFM)
`endif
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .bus       (bus),
        .occupancy (occ),
        .full      (full),
        .pack_err  (perr)
`ifdef FIFO_ALMOST_FULL_EN
        ,
        .almost_full (af)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    byte unsigned     m_bytes[$];
    bit               m_pending = 1'b0;
    logic [WIDTH-1:0] m_word    = '0;
    int               m_occ     = 0;
    bit               m_err     = 1'b0;
    bit               chk_en    = 1'b0;

    function automatic logic [WIDTH-1:0] pack(input byte unsigned b[$]);
        logic [WIDTH-1:0] w;
        w = '0;
        foreach (b[i]) w[i*BW +: BW] = b[i];
        return w;
    endfunction

    always @(posedge clk) begin
        bit we;
        if (rst) begin
            m_bytes.delete();
            m_pending = 1'b0;
            m_word    = '0;
            m_occ     = 0;
            m_err     = 1'b0;
            chk_en    = 1'b1;
        end else begin
            we = m_pending && (m_occ != DEPTH);
            if (we && !bus.mem_rd_en) m_occ = m_occ + 1;
            else if (bus.mem_rd_en && !we && m_occ > 0) m_occ = m_occ - 1;
            if (bus.wr_full_err) m_err = 1'b1;
            if (we) begin
                m_pending = 1'b0;
                m_bytes.delete();
            end else if (!m_pending && bus.in_valid) begin
                m_bytes.push_back(bus.in_data);
                if (m_bytes.size() == NBPW || bus.in_last) begin
                    m_pending = 1'b1;
                    m_word    = pack(m_bytes);
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", bus.in_ready, !m_pending);
            chk("mem_wr_en", bus.mem_wr_en, m_pending && (m_occ != DEPTH));
            if (m_pending) chk("fifo_wr_data", bus.fifo_wr_data, m_word);
            chk("occupancy", occ, m_occ);
            chk("full", full, m_occ == DEPTH);
            chk("pack_err", perr, m_err);
`ifdef FIFO_ALMOST_FULL_EN
            chk("almost_full", af, m_occ >= DEPTH - AFM);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        bit r;
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #1;
            if (r) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte %0h not accepted within 64 cycles", b);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) send(t[i*8 +: 8], 1'b0);
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_data     = '0;
        bus.in_last     = 1'b0;
        bus.mem_rd_en   = 1'b0;
        bus.wr_full_err = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_mem_wr_en", bus.mem_wr_en, 1'b0);
        chk("rst_wr_data", bus.fifo_wr_data, 32'h0);
        chk("rst_occ", occ, 6'd0);
        chk("rst_full", full, 1'b0);
        chk("rst_pack_err", perr, 1'b0);

        // Full word, back-to-back bytes; write one cycle after the 4th byte
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        chk("w1_latency_wr_en", bus.mem_wr_en, 1'b1);
        chk("w1_data", bus.fifo_wr_data, 32'h44332211);
        chk("w1_model_word", m_word, 32'h44332211);
        tick(1);
        chk("w1_occ", occ, 6'd1);
        chk("w1_model_occ", m_occ, 1);
        chk("w1_single_strobe", bus.mem_wr_en, 1'b0);

        // Flush with in_last, then a word starting again at lane 0
        send(8'hAA, 1'b0); send(8'hBB, 1'b1);
        chk("flush_data", bus.fifo_wr_data, 32'h0000BBAA);
        chk("flush_wr_en", bus.mem_wr_en, 1'b1);
        tick(1);
        send_word(32'hFFEEDDCC);
        chk("after_flush_data", bus.fifo_wr_data, 32'hFFEEDDCC);
        tick(1);
        chk("occ3", occ, 6'd3);

        // in_last on the 4th byte behaves like a normal completion
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
        chk("last_on_full_word", bus.fifo_wr_data, 32'h04030201);
        tick(1);

        // Fill to capacity (4 written so far)
        for (int i = 0; i < 28; i++) send_word(32'h1000_0000 + i);
        tick(1);
        chk("cap_occ", occ, 6'd32);
        chk("cap_full", full, 1'b1);

        // 33rd word is held while full
        send_word(32'hDEADBEEF);
        chk("held_wr_en", bus.mem_wr_en, 1'b0);
        chk("held_in_ready", bus.in_ready, 1'b0);
        tick(3);
        chk("held2_wr_en", bus.mem_wr_en, 1'b0);
        chk("held2_occ", occ, 6'd32);
        // Read while full: push still waits one cycle
        bus.mem_rd_en = 1'b1;
        chk("rd_full_wr_en", bus.mem_wr_en, 1'b0);
        tick(1);
        bus.mem_rd_en = 1'b0;
        chk("rd_occ31", occ, 6'd31);
        chk("rd_release_wr_en", bus.mem_wr_en, 1'b1);
        chk("rd_release_data", bus.fifo_wr_data, 32'hDEADBEEF);
        tick(1);
        chk("refill_occ", occ, 6'd32);
        chk("refill_full", full, 1'b1);
        chk("refill_in_ready", bus.in_ready, 1'b1);

        // Drain to 5, then simultaneous write and read
        bus.mem_rd_en = 1'b1;
        tick(27);
        bus.mem_rd_en = 1'b0;
        chk("drain_occ5", occ, 6'd5);
        send_word(32'hCAFEF00D);
        chk("simul_wr_en", bus.mem_wr_en, 1'b1);
        bus.mem_rd_en = 1'b1;
        tick(1);
        bus.mem_rd_en = 1'b0;
        chk("simul_occ5", occ, 6'd5);

        // Reads past empty hold at zero
        bus.mem_rd_en = 1'b1;
        tick(7);
        bus.mem_rd_en = 1'b0;
        chk("empty_occ0", occ, 6'd0);
        chk("empty_model_occ", m_occ, 0);

        // Reset with a partial word discards it
        send(8'h55, 1'b0); send(8'h66, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_in_ready", bus.in_ready, 1'b1);
        chk("midrst_occ", occ, 6'd0);
        send_word(32'h04030201);
        chk("midrst_data", bus.fifo_wr_data, 32'h04030201);
        tick(1);

`ifdef FIFO_ALMOST_FULL_EN
        // almost_full rises exactly when occupancy reaches 28
        for (int i = 0; i < 27; i++) send_word(32'h2000_0000 + i);
        tick(1);
        chk("af_occ27", occ, 6'd28);
        chk("af_at_28", af, 1'b1);
        bus.mem_rd_en = 1'b1;
        tick(1);
        bus.mem_rd_en = 1'b0;
        chk("af_at_27", af, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
`endif

        // Sticky overflow flag
        bus.wr_full_err = 1'b1;
        tick(1);
        bus.wr_full_err = 1'b0;
        chk("perr_set", perr, 1'b1);
        tick(5);
        chk("perr_held", perr, 1'b1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("perr_cleared", perr, 1'b0);
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
